// File: rtl/sobel_pkg.sv
// Shared types and defaults for the Sobel accelerator front end.
//   pixel_t      : one RGB888 pixel
//   ctrl_state_t : window controller sequencing states
package sobel_pkg;

  localparam int DEF_WIDTH      = 100;
  localparam int DEF_HEIGHT     = 100;
  localparam int DEF_DATA_WIDTH = 24;

  typedef logic [DEF_DATA_WIDTH-1:0] pixel_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PRIME  = 2'd1,
    ACTIVE = 2'd2,
    DONE   = 2'd3
  } ctrl_state_t;

endpackage

// File: rtl/sobel_pos_counter.sv
// Column/row position counter for a WIDTH x HEIGHT raster.
//   clk, rst_n : clock, async active-low reset
//   clr        : synchronous clear of both counters
//   adv        : advance one pixel position
//   col, row   : current position (position of the next pixel)
//   wrap       : combinational strobe, adv at the last column of a row
// The row counter is not wrapped; the owner clears it at frame start.
module sobel_pos_counter #(
  parameter int WIDTH  = 100,
  parameter int HEIGHT = 100
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clr,
  input  logic                      adv,
  output logic [$clog2(WIDTH)-1:0]  col,
  output logic [$clog2(HEIGHT)-1:0] row,
  output logic                      wrap
);

  localparam int CW = $clog2(WIDTH);
  localparam int RW = $clog2(HEIGHT);
  localparam logic [CW-1:0] COL_MAX = CW'(WIDTH - 1);

  assign wrap = adv && (col == COL_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (clr) begin
      col <= '0;
      row <= '0;
    end else if (adv) begin
      if (wrap) begin
        col <= '0;
        row <= row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

endmodule

// File: rtl/sobel_window_ctrl.sv
// Sobel window controller: feeds one WIDTH x HEIGHT frame into the 3-row
// line buffer and flags when a full 3x3 window is present.
//   start               : begin a frame (honoured in IDLE only)
//   s_valid/s_ready     : pixel input handshake, s_data pixel, s_last frame end
//   m_ready             : downstream kernel can take a window
//   shift_en, fifo_data : line buffer shift strobe and data_in
//   win_valid/col/row   : window present, position of its newest pixel
//   busy, done, len_err : frame in progress, end pulse, sticky length error
//
// state  | meaning
// IDLE   | waiting for start, no pixels accepted
// PRIME  | filling line buffer rows 0 and 1
// ACTIVE | streaming, windows produced from row 2 on
// DONE   | one-cycle end-of-frame pulse
module sobel_window_ctrl
  import sobel_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int HEIGHT     = DEF_HEIGHT,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      s_valid,
  input  logic [DATA_WIDTH-1:0]     s_data,
  input  logic                      s_last,
  output logic                      s_ready,
  input  logic                      m_ready,
  output logic                      shift_en,
  output logic [DATA_WIDTH-1:0]     fifo_data,
  output logic                      win_valid,
  output logic [$clog2(WIDTH)-1:0]  win_col,
  output logic [$clog2(HEIGHT)-1:0] win_row,
  output logic                      busy,
  output logic                      done,
  output logic                      len_err
);

  localparam int CW = $clog2(WIDTH);
  localparam int RW = $clog2(HEIGHT);
  localparam logic [RW-1:0] ROW_MAX = RW'(HEIGHT - 1);

  ctrl_state_t state_q, state_d;

  logic          beat;
  logic          frame_clr;
  logic          row_end;
  logic          final_beat;
  logic [CW-1:0] col;
  logic [RW-1:0] row;

  assign s_ready   = ((state_q == PRIME) || (state_q == ACTIVE)) && m_ready;
  assign beat      = s_valid && s_ready;
  assign shift_en  = beat;
  assign fifo_data = s_data;
  assign busy      = (state_q == PRIME) || (state_q == ACTIVE);
  assign done      = (state_q == DONE);
  assign frame_clr = (state_q == IDLE) && start;
  // row_end is the wrap strobe, so it already includes the accepted beat
  assign final_beat = row_end && (row == ROW_MAX);

  sobel_pos_counter #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT)
  ) u_pos (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (frame_clr),
    .adv   (beat),
    .col   (col),
    .row   (row),
    .wrap  (row_end)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = PRIME;
      PRIME:   if (row_end && (row == RW'(1))) state_d = ACTIVE;
      ACTIVE:  if (final_beat) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Registered to line up with the line buffer rows, which shift on the
  // same edge that accepts the beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_valid <= 1'b0;
      win_col   <= '0;
      win_row   <= '0;
    end else begin
      win_valid <= beat && (row >= RW'(2)) && (col >= CW'(2));
      if (beat && (row >= RW'(2)) && (col >= CW'(2))) begin
        win_col <= col;
        win_row <= row;
      end
    end
  end

  // The frame always ends on position count; s_last only feeds the flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                len_err <= 1'b0;
    else if (frame_clr)                        len_err <= 1'b0;
    else if (beat && (s_last != final_beat))   len_err <= 1'b1;
  end

endmodule
